// File: rtl/fp_div_pkg.sv
// Shared types and constants for the double-precision divide result collector.
// Provides the result record carried through the FIFO and the IEEE class helper.
package fp_div_pkg;

  localparam int DATA_W         = 64;
  localparam int EXP_W          = 11;
  localparam int MANT_W         = 52;
  localparam int TAG_W          = 6;
  localparam int FP_DIV_LATENCY = 16;

  typedef logic [TAG_W-1:0] div_tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    div_tag_t          tag;
    logic [2:0]        exc;
  } div_result_t;

  // Returns {nan, inf, zero} for an IEEE binary64 exponent/mantissa pair.
  function automatic logic [2:0] classify_exc(input logic [EXP_W-1:0]  exp_f,
                                              input logic [MANT_W-1:0] mant);
    logic exp_ones;
    logic exp_zero;
    logic mant_zero;
    exp_ones  = &exp_f;
    exp_zero  = (exp_f == '0);
    mant_zero = (mant == '0);
    return {exp_ones & ~mant_zero, exp_ones & mant_zero, exp_zero & mant_zero};
  endfunction

endpackage

// File: rtl/fp_div_result_fifo.sv
// Synchronous FIFO of divide results with full/empty flags; the head is read from storage flops.
// Exception bits are only stored when FP_DIV_EXC_CLASS_EN is defined.
module fp_div_result_fifo
  import fp_div_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        wr_en,
  input  div_result_t wr_data,
  input  logic        rd_en,
  output div_result_t rd_data,
  output logic        full,
  output logic        empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  div_tag_t          tag_q  [DEPTH];
  div_tag_t          tag_d  [DEPTH];
`ifdef FP_DIV_EXC_CLASS_EN
  logic [2:0]        exc_q  [DEPTH];
  logic [2:0]        exc_d  [DEPTH];
`else
  logic              unused_exc;
  assign unused_exc = ^wr_data.exc;
`endif

  assign wr_addr = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr = rd_ptr_q[ADDR_W-1:0];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    tag_d    = tag_q;
`ifdef FP_DIV_EXC_CLASS_EN
    exc_d    = exc_q;
`endif
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) begin
        data_d[wr_addr] = wr_data.data;
        tag_d[wr_addr]  = wr_data.tag;
`ifdef FP_DIV_EXC_CLASS_EN
        exc_d[wr_addr]  = wr_data.exc;
`endif
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_comb begin
    rd_data      = '0;
    rd_data.data = data_q[rd_addr];
    rd_data.tag  = tag_q[rd_addr];
`ifdef FP_DIV_EXC_CLASS_EN
    rd_data.exc  = exc_q[rd_addr];
`endif
  end

  // Storage is reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
`ifdef FP_DIV_EXC_CLASS_EN
        exc_q[i]  <= '0;
`endif
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
`ifdef FP_DIV_EXC_CLASS_EN
      exc_q    <= exc_d;
`endif
    end
  end

endmodule

// File: rtl/fp_div_result_collector.sv
// Collects results from the fixed-latency divider in issue order behind a credit-throttled issue port.
// Define FP_DIV_EXC_CLASS_EN to classify each result as {nan, inf, zero} on out_exc.
module fp_div_result_collector
  import fp_div_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int LATENCY    = FP_DIV_LATENCY,
  parameter int TAG_WIDTH  = TAG_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [TAG_WIDTH-1:0]  issue_tag,
  output logic                  issue_ready,
  input  logic [DATA_WIDTH-1:0] div_res,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [2:0]            out_exc,
  input  logic                  out_ready
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);

  logic [LATENCY-1:0] vld_q, vld_d;
  div_tag_t           tag_q [LATENCY];
  div_tag_t           tag_d [LATENCY];
  logic [CRED_W-1:0]  credits_q, credits_d;
  logic               accept, pop, capture;
  logic               fifo_full, fifo_empty;
  div_result_t        cap_entry, head;

  assign issue_ready = (credits_q != '0) && !flush;
  assign accept      = issue_valid && issue_ready;
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready && !flush;
  assign capture     = vld_q[LATENCY-1] && !flush;

  // The divider never stalls, so the tracking line shifts every cycle.
  always_comb begin
    vld_d = '0;
    tag_d = tag_q;
    if (!flush) begin
      vld_d[0] = accept;
      tag_d[0] = issue_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (flush) begin
      credits_d = CRED_W'(FIFO_DEPTH);
    end else if (accept && !pop) begin
      credits_d = credits_q - CRED_W'(1);
    end else if (pop && !accept) begin
      credits_d = credits_q + CRED_W'(1);
    end
  end

  always_comb begin
    cap_entry      = '0;
    cap_entry.data = div_res;
    cap_entry.tag  = tag_q[LATENCY-1];
`ifdef FP_DIV_EXC_CLASS_EN
    cap_entry.exc  = classify_exc(div_res[DATA_W-2 -: EXP_W], div_res[MANT_W-1:0]);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q     <= '0;
      credits_q <= CRED_W'(FIFO_DEPTH);
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      credits_q <= credits_d;
      tag_q     <= tag_d;
    end
  end

  fp_div_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_en   (capture),
    .wr_data (cap_entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_data = head.data;
  assign out_tag  = head.tag;
`ifdef FP_DIV_EXC_CLASS_EN
  assign out_exc  = head.exc;
`else
  logic unused_head_exc;
  assign unused_head_exc = ^head.exc;
  assign out_exc  = 3'b000;
`endif

  // Credits bound in-flight plus buffered ops, so a capture can never meet a full buffer.
  capture_never_full: assert property (@(posedge clk) disable iff (!rst) !(capture && fifo_full));

endmodule
